mem_arbiter: RTL and testbench

Shares one multi-cycle, single-ported unified memory between the fetch stage's instruction port (I-side) and the memory stage's data port (D-side). Each requester sees a stallmem-style interface: level request, `Stall` while waiting, one-cycle `Done` with data. The block sits between the fetch/memory stages and the memory instance. It owns all sequencing of that memory, including request issue, priority with anti-starvation, and a watchdog for lost completions.

---
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter over one multi-cycle unified memory (I-side fetch, D-side data).
// D-side wins ties unless the I-side has waited STARVE_MAX grants; a watchdog aborts lost accesses.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_Rd,
  input  logic [15:0] i_Addr,
  output logic [15:0] i_DataOut,
  output logic        i_Done,
  output logic        i_Stall,
  input  logic        d_Rd,
  input  logic        d_Wr,
  input  logic [15:0] d_Addr,
  input  logic [15:0] d_DataIn,
  output logic [15:0] d_DataOut,
  output logic        d_Done,
  output logic        d_Stall,
  output logic        mem_Rd,
  output logic        mem_Wr,
  output logic [15:0] mem_Addr,
  output logic [15:0] mem_DataIn,
  input  logic [15:0] mem_DataOut,
  input  logic        mem_Done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

  state_t      state;
  logic        owner;
  logic        op_wr;
  logic [3:0]  starve_cnt;
  logic [7:0]  to_cnt;

  logic        d_conflict;
  logic        d_req;
  logic        grant_i;
  logic        grant_d;
  logic        expired;
  logic        finish;
  logic [15:0] rdata;

  assign d_conflict = d_Rd & d_Wr;
  assign d_req      = d_Rd ^ d_Wr;
  assign grant_i    = i_Rd & (~d_req | (starve_cnt == STARVE_LIM));
  assign grant_d    = d_req & ~grant_i;

  // to_cnt holds (n-1) in the n-th ISSUE/WAIT cycle of an access
  assign expired = (state == WAIT) & (to_cnt == TO_LAST);
  assign finish  = (state == WAIT) & (mem_Done | expired);
  assign rdata   = (mem_Done & ~op_wr) ? mem_DataOut : 16'h0000;

  assign i_Done    = finish & ~owner & i_Rd;
  assign d_Done    = finish & owner & (d_Rd | d_Wr);
  assign i_DataOut = i_Done ? rdata : 16'h0000;
  assign d_DataOut = d_Done ? rdata : 16'h0000;
  assign i_Stall   = ~rst & i_Rd & ~i_Done;
  assign d_Stall   = ~rst & (d_Rd | d_Wr) & ~d_Done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      op_wr      <= 1'b0;
      starve_cnt <= 4'd0;
      to_cnt     <= 8'd0;
      mem_Rd     <= 1'b0;
      mem_Wr     <= 1'b0;
      mem_Addr   <= 16'h0000;
      mem_DataIn <= 16'h0000;
      err        <= 1'b0;
    end else begin
      mem_Rd <= 1'b0;
      mem_Wr <= 1'b0;
      if (mem_Done && state != WAIT)
        err <= 1'b1;
      unique case (state)
        IDLE: begin
          if (d_conflict)
            err <= 1'b1;
          if (!i_Rd)
            starve_cnt <= 4'd0;
          if (grant_i || grant_d) begin
            state      <= ISSUE;
            to_cnt     <= 8'd0;
            owner      <= grant_d;
            op_wr      <= grant_d & d_Wr;
            mem_Addr   <= grant_d ? d_Addr : i_Addr;
            mem_DataIn <= (grant_d & d_Wr) ? d_DataIn : 16'h0000;
            mem_Rd     <= ~(grant_d & d_Wr);
            mem_Wr     <= grant_d & d_Wr;
            if (grant_i)
              starve_cnt <= 4'd0;
            else if (i_Rd && starve_cnt != STARVE_LIM)
              starve_cnt <= starve_cnt + 4'd1;
          end
        end
        ISSUE: begin
          state  <= WAIT;
          to_cnt <= to_cnt + 8'd1;
        end
        WAIT: begin
          to_cnt <= to_cnt + 8'd1;
          if (finish) begin
            state <= IDLE;
            if (!mem_Done)
              err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single accesses plus
// hand-written arbitration, starvation, timeout, reset and conflict sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_Rd;
  logic [15:0] i_Addr;
  logic [15:0] i_DataOut;
  logic        i_Done;
  logic        i_Stall;
  logic        d_Rd;
  logic        d_Wr;
  logic [15:0] d_Addr;
  logic [15:0] d_DataIn;
  logic [15:0] d_DataOut;
  logic        d_Done;
  logic        d_Stall;
  logic        mem_Rd;
  logic        mem_Wr;
  logic [15:0] mem_Addr;
  logic [15:0] mem_DataIn;
  logic [15:0] mem_DataOut;
  logic        mem_Done;
  logic        err;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .i_Rd(i_Rd), .i_Addr(i_Addr), .i_DataOut(i_DataOut),
    .i_Done(i_Done), .i_Stall(i_Stall),
    .d_Rd(d_Rd), .d_Wr(d_Wr), .d_Addr(d_Addr), .d_DataIn(d_DataIn),
    .d_DataOut(d_DataOut), .d_Done(d_Done), .d_Stall(d_Stall),
    .mem_Rd(mem_Rd), .mem_Wr(mem_Wr), .mem_Addr(mem_Addr),
    .mem_DataIn(mem_DataIn), .mem_DataOut(mem_DataOut),
    .mem_Done(mem_Done), .err(err)
  );

  // memory model: latency lat (0 = never answers), Done in cycle issue+lat
  logic [15:0] mem [256];
  logic [15:0] rdata_m;
  int          cnt_m;
  int          lat;
  logic        force_done;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 256; k++) mem[k] <= 16'h0000;
      mem[8'h40] <= 16'hABCD;
      mem[8'h41] <= 16'h1234;
      cnt_m      <= 0;
      rdata_m    <= 16'h0000;
    end else begin
      if (mem_Wr) mem[mem_Addr[7:0]] <= mem_DataIn;
      if ((mem_Rd || mem_Wr) && lat != 0) begin
        cnt_m   <= lat;
        rdata_m <= mem[mem_Addr[7:0]];
      end else if (cnt_m != 0) begin
        cnt_m <= cnt_m - 1;
      end
    end
  end

  assign mem_Done    = (cnt_m == 1) | force_done;
  assign mem_DataOut = mem_Done ? rdata_m : 16'h0000;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic outs_any();
    return |{i_DataOut, i_Done, i_Stall, d_DataOut, d_Done, d_Stall,
             mem_Rd, mem_Wr, mem_Addr, mem_DataIn, err};
  endfunction

  typedef struct {
    logic        is_d;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] exp_data;
    int          exp_lat;
  } vec_t;

  task automatic run_txn(input vec_t v, input string tag);
    int c, done_c, strobe_c, strobes;
    logic [15:0] got, addr_s, data_s;
    logic wr_s, bad_other, bad_zero, stall_done;
    c = 0; done_c = -1; strobe_c = -1; strobes = 0;
    got = 16'h0; addr_s = 16'h0; data_s = 16'h0; wr_s = 1'b0;
    bad_other = 1'b0; bad_zero = 1'b0; stall_done = 1'b1;
    lat = v.lat;
    if (v.is_d) begin
      d_Addr = v.addr; d_DataIn = v.wdata; d_Rd = ~v.wr; d_Wr = v.wr;
    end else begin
      i_Addr = v.addr; i_Rd = 1'b1;
    end
    while (done_c < 0 && c < 40) begin
      @(negedge clk);
      if (c == 0)
        chk({tag, " stall0"}, 32'(v.is_d ? d_Stall : i_Stall), 32'd1);
      if (mem_Rd || mem_Wr) begin
        strobes++; strobe_c = c;
        addr_s = mem_Addr; data_s = mem_DataIn; wr_s = mem_Wr;
      end
      if (v.is_d ? i_Done : d_Done) bad_other = 1'b1;
      if (v.is_d ? d_Done : i_Done) begin
        done_c = c;
        got = v.is_d ? d_DataOut : i_DataOut;
        stall_done = v.is_d ? d_Stall : i_Stall;
      end else if (i_DataOut != 16'h0 || d_DataOut != 16'h0) begin
        bad_zero = 1'b1;
      end
      tick();
      c++;
    end
    i_Rd = 1'b0; d_Rd = 1'b0; d_Wr = 1'b0;
    chk({tag, " done_cycle"}, 32'(done_c), 32'(v.exp_lat));
    chk({tag, " data"}, 32'(got), 32'(v.exp_data));
    chk({tag, " stall_at_done"}, 32'(stall_done), 32'd0);
    chk({tag, " strobes"}, 32'(strobes), 32'd1);
    chk({tag, " strobe_cycle"}, 32'(strobe_c), 32'd1);
    chk({tag, " mem_addr"}, 32'(addr_s), 32'(v.addr));
    chk({tag, " mem_wr"}, 32'(wr_s), 32'(v.wr));
    if (v.wr) chk({tag, " mem_datain"}, 32'(data_s), 32'(v.wdata));
    chk({tag, " other_done"}, 32'(bad_other), 32'd0);
    chk({tag, " dataout_zero"}, 32'(bad_zero), 32'd0);
    tick();
  endtask

  vec_t vecs[6];
  vec_t vt;

  initial begin
    int c, n, i_c, d_c, is_c;
    logic [5:0] ev;
    logic flag_a, flag_b, saw_md, drop_i;
    logic [15:0] is_addr;

    vecs[0] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 3, 16'hABCD, 4};
    vecs[1] = '{1'b1, 1'b1, 16'h1000, 16'h5A5A, 2, 16'h0000, 3};
    vecs[2] = '{1'b1, 1'b0, 16'h1000, 16'h0000, 1, 16'h5A5A, 2};
    vecs[3] = '{1'b0, 1'b0, 16'h0041, 16'h0000, 4, 16'h1234, 5};
    vecs[4] = '{1'b1, 1'b1, 16'h00FF, 16'hFFFF, 1, 16'h0000, 2};
    vecs[5] = '{1'b0, 1'b0, 16'h00FF, 16'h0000, 2, 16'hFFFF, 3};

    rst = 1'b1; i_Rd = 1'b1; i_Addr = 16'h0; d_Rd = 1'b0; d_Wr = 1'b0;
    d_Addr = 16'h0; d_DataIn = 16'h0; force_done = 1'b0; lat = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", 32'(outs_any()), 32'd0);
    i_Rd = 1'b0;
    #1 rst = 1'b0;
    tick();

    for (int k = 0; k < 6; k++) run_txn(vecs[k], $sformatf("vec%0d", k));

    // simultaneous I and D read: D first, I issues in the IDLE after d_Done
    lat = 2; i_Addr = 16'h0040; d_Addr = 16'h0041; i_Rd = 1'b1; d_Rd = 1'b1;
    i_c = -1; d_c = -1; is_c = -1; is_addr = 16'h0;
    flag_a = 1'b1; flag_b = 1'b1;
    for (c = 0; c < 20 && i_c < 0; c++) begin
      @(negedge clk);
      if (d_Done) begin d_c = c; flag_a = d_Stall; end
      if (c == 3) chk("sim i_stall_waiting", 32'(i_Stall), 32'd1);
      if (c == 4) flag_b = d_Stall;
      if (i_Done) i_c = c;
      if (mem_Rd && d_c >= 0) begin is_c = c; is_addr = mem_Addr; end
      tick();
      if (d_c >= 0) d_Rd = 1'b0;
    end
    i_Rd = 1'b0;
    chk("sim d_done_cycle", 32'(d_c), 32'd3);
    chk("sim d_stall_at_done", 32'(flag_a), 32'd0);
    chk("sim d_stall_after", 32'(flag_b), 32'd0);
    chk("sim i_issue_cycle", 32'(is_c), 32'd5);
    chk("sim i_issue_addr", 32'(is_addr), 32'h0040);
    chk("sim i_done_cycle", 32'(i_c), 32'd7);
    tick();

    // starvation: I held while D re-requests continuously
    lat = 1; i_Addr = 16'h0040; d_Addr = 16'h0041; i_Rd = 1'b1; d_Rd = 1'b1;
    n = 0; ev = 6'b0; flag_a = 1'b0; flag_b = 1'b0; drop_i = 1'b0;
    for (c = 0; c < 100 && n < 6; c++) begin
      @(negedge clk);
      if (i_Done && d_Done) flag_a = 1'b1;
      if (i_Done) begin
        ev = {ev[4:0], 1'b1}; n++; drop_i = 1'b1;
        if (i_DataOut != 16'hABCD) flag_b = 1'b1;
      end
      if (d_Done) begin
        ev = {ev[4:0], 1'b0}; n++;
        if (d_DataOut != 16'h1234) flag_b = 1'b1;
      end
      tick();
      if (drop_i) i_Rd = 1'b0;
    end
    d_Rd = 1'b0; i_Rd = 1'b0;
    chk("starve count", 32'(n), 32'd6);
    chk("starve order", 32'(ev), 32'(6'b000010));
    chk("starve both_done", 32'(flag_a), 32'd0);
    chk("starve data", 32'(flag_b), 32'd0);
    tick();

    // watchdog: memory never answers
    chk("err before timeout", 32'(err), 32'd0);
    vt = '{1'b0, 1'b0, 16'h0077, 16'h0000, 0, 16'h0000, 15};
    run_txn(vt, "timeout");
    chk("err after timeout", 32'(err), 32'd1);
    repeat (3) tick();
    chk("err sticky", 32'(err), 32'd1);

    // async reset mid-WAIT, then a late mem_Done
    lat = 5; i_Addr = 16'h0041; i_Rd = 1'b1;
    repeat (3) tick();
    #5 rst = 1'b1;
    i_Rd = 1'b0;
    #1;
    chk("rst async outputs", 32'(outs_any()), 32'd0);
    #1 rst = 1'b0;
    flag_a = 1'b0; saw_md = 1'b0;
    for (c = 4; c < 8; c++) begin
      @(negedge clk);
      if (i_Done || d_Done) flag_a = 1'b1;
      if (mem_Done) saw_md = 1'b1;
      tick();
    end
    chk("rst late memdone seen", 32'(saw_md), 32'd1);
    chk("rst no done", 32'(flag_a), 32'd0);
    chk("rst late err", 32'(err), 32'd1);
    vt = '{1'b0, 1'b0, 16'h0040, 16'h0000, 2, 16'hABCD, 3};
    run_txn(vt, "post_rst");

    // d_Rd & d_Wr together: error, only I is served
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    tick();
    chk("err cleared by rst", 32'(err), 32'd0);
    lat = 1; i_Addr = 16'h0040; i_Rd = 1'b1;
    d_Addr = 16'h0041; d_Rd = 1'b1; d_Wr = 1'b1;
    i_c = -1; n = 0; d_c = 0;
    for (c = 0; c < 8; c++) begin
      @(negedge clk);
      if (i_Done) begin i_c = c; is_addr = i_DataOut; end
      if (d_Done) d_c++;
      if (mem_Rd || mem_Wr) n++;
      tick();
      if (i_c >= 0) i_Rd = 1'b0;
    end
    d_Rd = 1'b0; d_Wr = 1'b0;
    chk("conflict i_done_cycle", 32'(i_c), 32'd2);
    chk("conflict i_data", 32'(is_addr), 32'hABCD);
    chk("conflict d_done", 32'(d_c), 32'd0);
    chk("conflict strobes", 32'(n), 32'd1);
    chk("conflict err", 32'(err), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
